// File: rtl/rhs2116_cmd_scheduler.sv
// rhs2116_cmd_scheduler
//   Command scheduler between host/config logic and the RHS2116 SPI frame
//   engine (clk_spi domain). Runs a continuous CONVERT sweep over channels
//   0..NUM_CH-1, slips host WRITE/READ words in only at sweep boundaries,
//   tags every returned word with the command that produced it (the chip
//   answers LAT frames late) and flushes the pipeline with dummy reads when
//   the sweep is disabled.
//
// Ports
//   clk_spi, rst_n          clock, asynchronous active-low reset
//   enable                  sweep enable (sampled only when a frame completes)
//   cfg_valid/cfg_word      pending host command, word held while valid
//   cfg_ready               pulse in the cycle the host word is handed over
//   cmd_valid/cmd_word      command offered to the frame engine
//   cmd_ready               engine accepts the offered command
//   rsp_valid/rsp_word      frame completed, MISO word
//   res_valid/res_data      tagged result pulse and its data
//   res_is_cfg/res_chan     origin tag of the result
//   sweep_done              result of channel NUM_CH-1 delivered
//   busy                    scheduler not idle
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no command outstanding, waiting for enable
// S_ISSUE | offering a real command (CONVERT or host word)
// S_WAIT  | one command accepted, waiting for its frame to complete
// S_FLUSH | offering a DUMMY_CMD to push the last real results out
module rhs2116_cmd_scheduler #(
  parameter int          NUM_CH    = 16,
  parameter int          CFG_MAX   = 4,
  parameter int          LAT       = 2,
  parameter logic [31:0] DUMMY_CMD = 32'hE8FF0000
) (
  input  logic        clk_spi,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_word,
  output logic        cfg_ready,
  output logic        cmd_valid,
  output logic [31:0] cmd_word,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_word,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_is_cfg,
  output logic [3:0]  res_chan,
  output logic        sweep_done,
  output logic        busy
);

  localparam int               CNT_W     = $clog2(CFG_MAX + 1);
  localparam int               FL_W      = $clog2(LAT + 1);
  localparam logic [3:0]       LAST_CH   = 4'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CFG_MAX_C = CNT_W'(CFG_MAX);
  localparam logic [FL_W-1:0]  LAT_C     = FL_W'(LAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

  typedef struct packed {
    logic       valid;
    logic       is_cfg;
    logic [3:0] chan;
  } tag_t;

  state_t            state;
  logic [3:0]        chan;
  logic              cur_is_cfg;
  logic [CNT_W-1:0]  cfg_cnt;
  logic [FL_W-1:0]   flush_cnt;
  logic              flushing;
  // hist[0] is the newest accepted command, hist[LAT] the one whose result
  // arrives with the next completed frame.
  tag_t [LAT:0]      hist;

  logic              handshake;
  logic              at_boundary;
  tag_t              issue_tag;
  tag_t              res_tag;

  function automatic logic [31:0] convert_word(input logic [3:0] c);
    return {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, c, 16'h0000};
  endfunction

  assign handshake   = cmd_valid && cmd_ready;
  assign at_boundary = cur_is_cfg || (chan == LAST_CH);
  assign issue_tag   = '{valid: 1'b1, is_cfg: cur_is_cfg,
                         chan: (cur_is_cfg ? 4'd0 : chan)};
  assign res_tag     = hist[LAT];
  assign cfg_ready   = handshake && (state == S_ISSUE) && cur_is_cfg;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_valid  <= 1'b0;
      cmd_word   <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_is_cfg <= 1'b0;
      res_chan   <= '0;
      sweep_done <= 1'b0;
      chan       <= '0;
      cur_is_cfg <= 1'b0;
      cfg_cnt    <= '0;
      flush_cnt  <= '0;
      flushing   <= 1'b0;
      hist       <= '0;
    end else begin
      res_valid  <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state      <= S_ISSUE;
            cmd_valid  <= 1'b1;
            cmd_word   <= convert_word(chan);
            cur_is_cfg <= 1'b0;
          end
        end

        S_ISSUE: begin
          if (handshake) begin
            cmd_valid <= 1'b0;
            hist      <= {hist[LAT-1:0], issue_tag};
            state     <= S_WAIT;
          end
        end

        S_FLUSH: begin
          if (handshake) begin
            cmd_valid <= 1'b0;
            // dummy frames carry an invalid tag so their results are dropped
            hist      <= {hist[LAT-1:0], tag_t'('0)};
            flush_cnt <= flush_cnt + FL_W'(1);
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (rsp_valid) begin
            if (res_tag.valid) begin
              res_valid  <= 1'b1;
              res_data   <= rsp_word;
              res_is_cfg <= res_tag.is_cfg;
              res_chan   <= res_tag.chan;
              sweep_done <= !res_tag.is_cfg && (res_tag.chan == LAST_CH);
            end

            if (flushing) begin
              if (flush_cnt == LAT_C) begin
                state     <= S_IDLE;
                flushing  <= 1'b0;
                flush_cnt <= '0;
                hist      <= '0;
                chan      <= '0;
                cfg_cnt   <= '0;
              end else begin
                state     <= S_FLUSH;
                cmd_valid <= 1'b1;
                cmd_word  <= DUMMY_CMD;
              end
            end else if (!enable) begin
              // enable is latched here; re-asserting it cannot abort the flush
              flushing  <= 1'b1;
              state     <= S_FLUSH;
              cmd_valid <= 1'b1;
              cmd_word  <= DUMMY_CMD;
            end else begin
              state     <= S_ISSUE;
              cmd_valid <= 1'b1;
              if (!at_boundary) begin
                chan       <= chan + 4'd1;
                cur_is_cfg <= 1'b0;
                cmd_word   <= convert_word(chan + 4'd1);
              end else if (cfg_valid && (cfg_cnt < CFG_MAX_C)) begin
                // host word is captured now so the offer stays stable
                cur_is_cfg <= 1'b1;
                cmd_word   <= cfg_word;
                cfg_cnt    <= cfg_cnt + CNT_W'(1);
              end else begin
                cfg_cnt    <= '0;
                chan       <= '0;
                cur_is_cfg <= 1'b0;
                cmd_word   <= convert_word(4'd0);
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rhs2116_cmd_scheduler.sv
// Testbench for rhs2116_cmd_scheduler (NUM_CH=4, CFG_MAX=4).
// The main process plays host and frame engine; each run's expected command
// stream and tagged results are derived from whole sweeps plus batches of
// host words, shifted by the result latency. A separate monitor checks
// every res_valid pulse against the result queue.
module tb_rhs2116_cmd_scheduler;

  localparam int          NUM_CH  = 4;
  localparam int          CFG_MAX = 4;
  localparam int          LAT     = 2;
  localparam logic [31:0] DUMMY   = 32'hE8FF0000;

  typedef struct {
    logic [31:0] word;
    bit          is_cfg;
    logic [3:0]  chan;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    bit          is_cfg;
    logic [3:0]  chan;
    bit          sd;
  } res_t;

  logic        clk_spi;
  logic        rst_n;
  logic        enable;
  logic        cfg_valid;
  logic [31:0] cfg_word;
  logic        cfg_ready;
  logic        cmd_valid;
  logic [31:0] cmd_word;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_word;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_is_cfg;
  logic [3:0]  res_chan;
  logic        sweep_done;
  logic        busy;

  rhs2116_cmd_scheduler #(
    .NUM_CH(NUM_CH), .CFG_MAX(CFG_MAX), .LAT(LAT), .DUMMY_CMD(DUMMY)
  ) dut (
    .clk_spi(clk_spi), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_word(cfg_word), .cfg_ready(cfg_ready),
    .cmd_valid(cmd_valid), .cmd_word(cmd_word), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_word(rsp_word),
    .res_valid(res_valid), .res_data(res_data), .res_is_cfg(res_is_cfg),
    .res_chan(res_chan), .sweep_done(sweep_done), .busy(busy)
  );

  initial begin
    clk_spi = 1'b0;
    forever #8 clk_spi = ~clk_spi;
  end

  // main-process state
  cmd_t        exp_cmd[$];
  res_t        exp_res[$];
  logic [31:0] cfg_q[$];
  int          res_floor = 0;
  int          main_checks = 0, main_pass = 0;
  bit          eng_on, outstanding, held, pop_cfg, stray_req;
  int          rsp_cnt, stall_cnt, dmin, dmax, frame_idx, run_m, cfg_seen;
  logic [31:0] pend_word, held_word, salt;

  // monitor-process state
  int          res_rd = 0, res_seen = 0;
  int          mon_checks = 0, mon_pass = 0;

  function automatic logic [31:0] conv(input int c);
    return 32'h0800_0000 | (32'(c) << 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    main_checks++;
    if (act === exp) main_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // One clock of host + frame engine behaviour, driven at the falling edge.
  task automatic tick();
    cmd_t e;
    @(negedge clk_spi);
    rsp_valid = 1'b0;
    if (pop_cfg) begin
      void'(cfg_q.pop_front());
      pop_cfg = 1'b0;
    end
    cfg_valid = (cfg_q.size() > 0);
    cfg_word  = cfg_valid ? cfg_q[0] : 32'h0;
    if (!eng_on) begin
      cmd_ready   = 1'b0;
      outstanding = 1'b0;
      rsp_cnt     = 0;
      held        = 1'b0;
    end else begin
      if (outstanding) begin
        rsp_cnt--;
        if (rsp_cnt <= 0) begin
          rsp_valid   = 1'b1;
          rsp_word    = pend_word;
          outstanding = 1'b0;
        end
      end else if (stray_req) begin
        rsp_valid = 1'b1;
        rsp_word  = $urandom();
        stray_req = 1'b0;
      end
      if (stall_cnt > 0) begin
        cmd_ready = 1'b0;
        stall_cnt--;
      end else begin
        cmd_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (cmd_valid) begin
        chk("no_reissue", 32'(outstanding), 32'd0);
        if (held) chk("hold_word", cmd_word, held_word);
        if (cmd_ready) begin
          if (exp_cmd.size() == 0) begin
            main_checks++;
            $display("FAIL cmd_unexpected actual=%h required=none", cmd_word);
          end else begin
            e = exp_cmd.pop_front();
            chk("cmd_word", cmd_word, e.word);
            chk("cfg_ready_hs", 32'(cfg_ready), 32'(e.is_cfg));
          end
          if (cfg_ready) begin
            pop_cfg = 1'b1;
            cfg_seen++;
          end
          pend_word   = salt ^ 32'(frame_idx);
          frame_idx++;
          outstanding = 1'b1;
          rsp_cnt     = $urandom_range(dmin, dmax);
          held        = 1'b0;
          if (frame_idx == run_m) enable = 1'b0;
        end else begin
          chk("cfg_ready_stall", 32'(cfg_ready), 32'd0);
          held      = 1'b1;
          held_word = cmd_word;
        end
      end else begin
        held = 1'b0;
      end
    end
  endtask

  // Expected traffic for m real commands with p host words queued up front:
  // whole sweeps, each followed by up to CFG_MAX host words, then LAT dummies.
  // Result k is the tag of command k with the word of frame k+LAT.
  function automatic int prep(input int m, input int p, input logic [31:0] s);
    cmd_t        list[$];
    logic [31:0] words[$];
    int          ci = 0, ncfg = 0;
    for (int j = 0; j < p; j++) words.push_back($urandom());
    while (list.size() < m) begin
      for (int c = 0; c < NUM_CH && list.size() < m; c++)
        list.push_back('{word: conv(c), is_cfg: 1'b0, chan: 4'(c)});
      for (int j = 0; j < CFG_MAX && ci < p && list.size() < m; j++) begin
        list.push_back('{word: words[ci], is_cfg: 1'b1, chan: 4'd0});
        ci++;
        ncfg++;
      end
      // a truncated batch leaves the rest for the next boundary
      if (ci < p && list.size() < m && (ncfg % CFG_MAX) != 0) ncfg = ncfg;
    end
    foreach (list[k]) begin
      exp_cmd.push_back(list[k]);
      exp_res.push_back('{data: s ^ 32'(k + LAT), is_cfg: list[k].is_cfg,
                          chan: list[k].chan,
                          sd: !list[k].is_cfg && (int'(list[k].chan) == NUM_CH - 1)});
    end
    for (int j = 0; j < LAT; j++) exp_cmd.push_back('{word: DUMMY, is_cfg: 1'b0, chan: 4'd0});
    cfg_q     = words;
    salt      = s;
    frame_idx = 0;
    run_m     = m;
    cfg_seen  = 0;
    return ncfg;
  endfunction

  task automatic run(input int m, input int p, input logic [31:0] s,
                     input int stall0, input bit stray);
    int  ncfg;
    bit  done = 0;
    ncfg      = prep(m, p, s);
    stall_cnt = stall0;
    eng_on    = 1'b1;
    enable    = 1'b1;
    if (stray) begin
      for (int t = 0; t < 20 && !cmd_valid; t++) tick();
      stray_req = 1'b1;
    end
    for (int t = 0; t < 4000; t++) begin
      tick();
      if (frame_idx == m + LAT && !busy && !outstanding) begin
        done = 1;
        break;
      end
    end
    repeat (3) tick();
    chk("run_done", 32'(done), 32'd1);
    chk("cmd_all_issued", 32'(exp_cmd.size()), 32'd0);
    chk("cfg_ready_count", 32'(cfg_seen), 32'(ncfg));
    chk("res_all_delivered", 32'(res_rd), 32'(exp_res.size()));
    chk("busy_low_after", 32'(busy), 32'd0);
    exp_cmd.delete();
    cfg_q.delete();
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_cmd_valid"},  32'(cmd_valid), 32'd0);
    chk({tag, "_cmd_word"},   cmd_word, 32'd0);
    chk({tag, "_cfg_ready"},  32'(cfg_ready), 32'd0);
    chk({tag, "_res_valid"},  32'(res_valid), 32'd0);
    chk({tag, "_res_data"},   res_data, 32'd0);
    chk({tag, "_res_is_cfg"}, 32'(res_is_cfg), 32'd0);
    chk({tag, "_res_chan"},   32'(res_chan), 32'd0);
    chk({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
    chk({tag, "_busy"},       32'(busy), 32'd0);
  endtask

  // result monitor / scoreboard
  initial begin
    res_t e;
    forever begin
      @(posedge clk_spi);
      #1;
      if (res_rd < res_floor) res_rd = res_floor;
      if (rst_n && res_valid) begin
        res_seen++;
        mon_checks++;
        if (res_rd >= exp_res.size()) begin
          $display("FAIL res_unexpected actual=%h/%0d/%0d required=none",
                   res_data, res_is_cfg, res_chan);
        end else begin
          e = exp_res[res_rd];
          res_rd++;
          if (res_data === e.data && res_is_cfg === e.is_cfg &&
              res_chan === e.chan && sweep_done === e.sd)
            mon_pass++;
          else
            $display("FAIL res_tag actual=%h cfg=%0d ch=%0d sd=%0d required=%h cfg=%0d ch=%0d sd=%0d",
                     res_data, res_is_cfg, res_chan, sweep_done,
                     e.data, e.is_cfg, e.chan, e.sd);
        end
      end else if (rst_n && sweep_done) begin
        mon_checks++;
        $display("FAIL sweep_done_alone actual=1 required=0");
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
    rsp_word = '0; cfg_valid = 1'b0; cfg_word = '0;
    eng_on = 0; outstanding = 0; held = 0; pop_cfg = 0; stray_req = 0;
    rsp_cnt = 0; stall_cnt = 0; dmin = 1; dmax = 4; frame_idx = 0;
    run_m = 0; cfg_seen = 0; salt = '0; pend_word = '0; held_word = '0;

    tick(); tick(); #1;
    outputs_zero("reset");
    rst_n = 1'b1;
    tick(); #1;
    chk("idle_after_reset", 32'(busy), 32'd0);

    // stray response while idle
    eng_on    = 1'b1;
    stray_req = 1'b1;
    repeat (4) tick();
    chk("idle_stray_busy", 32'(busy), 32'd0);
    chk("idle_stray_nores", 32'(res_seen), 32'd0);

    // plain sweep, rsp_word = frame index
    run(10, 0, 32'h0, 0, 0);
    // six host words: four after the first sweep, two after the next
    run(20, 6, $urandom(), 0, 0);
    // disable right after the chan1 handshake
    run(2, 0, $urandom(), 0, 0);
    // long backpressure with a spurious response while offering
    run(9, 0, $urandom(), 10, 1);

    // reset in the middle of a frame
    begin
      int ncfg;
      ncfg   = prep(50, 0, $urandom());
      dmin   = 6;
      dmax   = 6;
      eng_on = 1'b1;
      enable = 1'b1;
      for (int t = 0; t < 500 && frame_idx < 3; t++) tick();
      chk("rst_reach_wait", 32'(frame_idx >= 3), 32'd1);
      tick();
      #2 rst_n = 1'b0;
      #1 outputs_zero("midrst");
      eng_on = 1'b0;
      enable = 1'b0;
      exp_cmd.delete();
      res_floor = exp_res.size();
      tick(); tick();
      rst_n = 1'b1;
      tick(); #1;
      outputs_zero("postrst");
      dmin = 1;
      dmax = 4;
    end
    // stray response before the first handshake after reset
    run(6, 0, $urandom(), 10, 1);

    for (int r = 0; r < 6; r++)
      run($urandom_range(1, 30), $urandom_range(0, 9), $urandom(),
          $urandom_range(0, 12), 1'($urandom_range(0, 1)));

    repeat (4) tick();
    $display("%0d/%0d checks passed", main_pass + mon_pass, main_checks + mon_checks);
    $finish;
  end

endmodule

// File: doc/rhs2116_cmd_scheduler.md
Name: rhs2116_cmd_scheduler

Overview:
- Command scheduler sitting between the host/config logic and the RHS2116 SPI frame engine, all in the clk_spi domain.
- Issues a continuous CONVERT sweep over channels 0..NUM_CH-1 and inserts host register commands (WRITE/READ) only at sweep boundaries.
- Tracks the RHS2116 two-frame result latency, tags every returned word with its originating command, and flushes the pipeline on disable.

Parameters:
- NUM_CH, 16, channels per sweep (1..16)
- CFG_MAX, 4, max config commands inserted per sweep boundary (>=1)
- LAT, 2, result latency in frames (fixed; documents the tag history depth)
- DUMMY_CMD, 32'hE8FF0000, word issued during flush (harmless read of register 255); its results are discarded

Ports:
- clk_spi  in  1  64 MHz SPI-domain clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  sweep enable, already synchronous to clk_spi
- cfg_valid  in  1  host command pending
- cfg_word  in  32  host command word, held stable while cfg_valid
- cfg_ready  out  1  one-cycle pulse when cfg_word is consumed
- cmd_valid  out  1  command offered to the frame engine
- cmd_word  out  32  command word
- cmd_ready  in  1  engine accepts cmd_word when cmd_valid && cmd_ready
- rsp_valid  in  1  one-cycle pulse, a frame completed
- rsp_word  in  32  MISO word of the completed frame
- res_valid  out  1  tagged result pulse
- res_data  out  32  result word
- res_is_cfg  out  1  result belongs to a host command
- res_chan  out  4  channel of a CONVERT result (0 when res_is_cfg)
- sweep_done  out  1  one-cycle pulse when the result of channel NUM_CH-1 is delivered
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, chan 0, tag history all invalid, cfg_cnt 0.
- CONVERT word: {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'b00, chan[3:0], 16'h0000}.
- One command outstanding at most. After a handshake, cmd_valid drops the next cycle and the scheduler waits for rsp_valid before offering again.
- A rsp_valid arriving with no command outstanding is ignored.
- States:
  - IDLE: if enable, go to ISSUE.
  - ISSUE: cmd_valid=1 with the selected word. On handshake, go to WAIT.
  - WAIT: on rsp_valid, process the result, select the next command, then go to ISSUE, FLUSH or IDLE.
  - FLUSH: issue exactly LAT DUMMY_CMD frames using the same ISSUE/WAIT handshake, then go to IDLE.
- Selection after a CONVERT of chan<NUM_CH-1: next is CONVERT chan+1.
- Selection after CONVERT chan NUM_CH-1, or after a config command (boundary):
  - if cfg_valid and cfg_cnt<CFG_MAX: issue cfg_word; cfg_ready pulses in the handshake cycle; cfg_cnt increments.
  - else: cfg_cnt clears and the sweep resumes at chan 0.
- cfg_valid is never sampled mid-sweep.
- Tag history h0..h2: each entry is {valid, is_cfg, chan}. On each handshake: h2<=h1, h1<=h0, h0<=tag of the new command. DUMMY tags have valid=0.
- On rsp_valid, the result tag is h2 (the command issued two frames earlier).
  - If h2.valid: the next cycle drives res_valid=1, res_data=rsp_word, res_is_cfg, res_chan.
  - Otherwise the word is discarded. This drops the first 2 frames after every start.
  - sweep_done pulses in the same cycle as res_valid when !h2.is_cfg && h2.chan==NUM_CH-1.
- Result latency: res_valid is registered, one cycle after rsp_valid.
- Disable: enable is sampled only at the rsp_valid decision point in WAIT. If low, enter FLUSH and deliver the 2 pending real results. enable going high during FLUSH does not abort the flush.
- Leaving FLUSH: the history is all invalid and chan resets to 0.
- Asynchronous reset mid-frame: immediate return to reset state; any in-flight engine response is later ignored.

Test Plan:
- Start, NUM_CH=4: enable=1, engine replies rsp_word=frame index → cmd_word chans 0,1,2,3,0…; first two rsp dropped; res_data=2 tagged chan0, res_data=3 tagged chan1; sweep_done with chan3.
- Config insertion: cfg_valid with 6 words during sweep → none issued mid-sweep; 4 issued after chan3 (4 cfg_ready pulses), sweep resumes chan0, remaining 2 after the next sweep; cfg results flagged res_is_cfg=1 two frames later.
- Disable flush: drop enable after chan1 handshake → chan1 completes, then 2 DUMMY_CMD frames; results for chan0 and chan1 delivered, dummies discarded; busy falls, state IDLE.
- Backpressure: cmd_ready low for 10 cycles → cmd_valid and cmd_word held stable, no duplicate issue, no tag shift.
- Reset mid-WAIT: assert rst_n low → all outputs 0 at once; after release plus enable, a stray rsp_valid before the first handshake produces no res_valid.
- Spurious rsp_valid in ISSUE/IDLE → ignored; tag history unchanged.
